// File: rtl/ic_bram_pkg.sv
// Shared types and sizing helpers for the CPU-to-BRAM bridge.
// Pipe entries carry request attributes while a BRAM read is in flight.
package ic_bram_pkg;

    localparam int DEF_RSP_DEPTH = 4;
    localparam int PTR_W         = $clog2(DEF_RSP_DEPTH);
    localparam int CNT_W         = PTR_W + 1;

    typedef struct packed {
        logic vld;
        logic err;
        logic wen;
    } pipe_ent_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    // Low-bit mask of a power-of-two window; callers truncate to their address width.
    function automatic logic [63:0] win_mask(input logic [63:0] size_bytes);
        return size_bytes - 64'd1;
    endfunction

endpackage

// File: rtl/ic_rsp_fifo.sv
// Synchronous response FIFO, head read straight from the storage registers.
// Push when full / pop when empty are dropped; the owner's credit counter prevents both.
module ic_rsp_fifo
    import ic_bram_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible while the pointers say empty.
    always_ff @(posedge g_clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ic_cpu_bram_bridge_pipe.sv
// CPU request/response bridge onto one BRAM bank; response appears BRAM_LATENCY+1 cycles after grant.
// Backpressure via an outstanding-request credit (no pop bypass); the latency pipe never stalls.
module ic_cpu_bram_bridge_pipe
    import ic_bram_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                BRAM_LATENCY = 1,
    parameter int                RSP_DEPTH    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] SIZE_BYTES   = 32'h0001_0000
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    output logic                bram_cen,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_wdata,
    output logic [DATA_W/8-1:0] bram_wstrb,
    input  logic                bram_stall,
    input  logic [DATA_W-1:0]   bram_rdata,
    input  logic                enable,
    input  logic                mem_req,
    output logic                mem_gnt,
    input  logic                mem_wen,
    input  logic [DATA_W/8-1:0] mem_strb,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_recv,
    input  logic                mem_ack,
    output logic                mem_error,
    output logic [DATA_W-1:0]   mem_rdata
);

    localparam int                OCNT_W   = cnt_w(RSP_DEPTH);
    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(win_mask(64'(SIZE_BYTES)));

    typedef struct packed {
        logic              error;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    logic              in_win;
    logic              credit;
    logic              req_ok;
    logic              gnt;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [OCNT_W-1:0] outstanding;
    pipe_ent_t         pipe_q [BRAM_LATENCY];
    pipe_ent_t         tail;
    rsp_t              push_ent;
    rsp_t              head_ent;

    // Request decode
    assign in_win  = ((mem_addr & ~WIN_MASK) == BASE_ADDR);
    assign credit  = (outstanding < OCNT_W'(RSP_DEPTH)) && !fifo_full;
    assign req_ok  = g_resetn && enable && mem_req && credit;
    assign gnt     = req_ok && (!in_win || !bram_stall);
    assign mem_gnt = gnt;

    assign bram_cen   = req_ok && in_win;
    assign bram_addr  = enable ? (mem_addr & WIN_MASK) : '0;
    assign bram_wstrb = mem_wen ? mem_strb : '0;
    assign bram_wdata = mem_wdata;

    // Fixed-latency pipe tracks each grant until its BRAM data is due.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < BRAM_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{vld: gnt, err: !in_win, wen: mem_wen};
            for (int i = 1; i < BRAM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tail = pipe_q[BRAM_LATENCY-1];

    always_comb begin
        push_ent.error = tail.err;
        push_ent.rdata = (tail.err || tail.wen) ? '0 : bram_rdata;
    end

    ic_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push     (tail.vld),
        .push_dat (push_ent),
        .pop      (pop),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .head     (head_ent)
    );

    assign mem_recv  = !fifo_empty;
    assign pop       = mem_recv && mem_ack;
    assign mem_error = mem_recv && head_ent.error;
    assign mem_rdata = mem_recv ? head_ent.rdata : '0;

    // Counts grants not yet popped, covering both the pipe and the FIFO.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            outstanding <= '0;
        end else if (gnt && !pop) begin
            outstanding <= outstanding + 1'b1;
        end else if (!gnt && pop) begin
            outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_ic_cpu_bram_bridge_pipe.sv
// Directed bench: default bridge (latency 1) plus a latency-3 instance sharing one BRAM image.
module tb_ic_cpu_bram_bridge_pipe;

    logic        g_clk;
    logic        g_resetn;
    logic        enable, mem_req, mem_wen, mem_ack, bram_stall;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata, mem_addr;
    logic        mem_gnt, mem_recv, mem_error, bram_cen;
    logic [31:0] mem_rdata, bram_addr, bram_wdata, bram_rdata;
    logic [3:0]  bram_wstrb;

    logic        u3_req;
    logic [31:0] u3_addr;
    logic        u3_gnt, u3_recv, u3_error, u3_cen;
    logic [31:0] u3_rdata, u3_baddr, u3_bwdata, u3_brdata;
    logic [3:0]  u3_bwstrb;

    logic [31:0] bmem [256];
    logic [31:0] rd0_q;
    logic [31:0] rd3_q [3];

    int n_vec = 0;
    int n_bad = 0;

    ic_cpu_bram_bridge_pipe u_dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .bram_cen   (bram_cen),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_stall (bram_stall),
        .bram_rdata (bram_rdata),
        .enable     (enable),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_addr   (mem_addr),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata)
    );

    ic_cpu_bram_bridge_pipe #(.BRAM_LATENCY(3), .RSP_DEPTH(4)) u_dut3 (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .bram_cen   (u3_cen),
        .bram_addr  (u3_baddr),
        .bram_wdata (u3_bwdata),
        .bram_wstrb (u3_bwstrb),
        .bram_stall (bram_stall),
        .bram_rdata (u3_brdata),
        .enable     (enable),
        .mem_req    (u3_req),
        .mem_gnt    (u3_gnt),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_addr   (u3_addr),
        .mem_recv   (u3_recv),
        .mem_ack    (mem_ack),
        .mem_error  (u3_error),
        .mem_rdata  (u3_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // BRAM model: image reloads during reset; word 4 holds DEADBEEF, others A000_00ii.
    always @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < 256; i++)
                bmem[i] <= (i == 4) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(i));
        end else if (bram_cen && !bram_stall) begin
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) bmem[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
    end

    always @(posedge g_clk) begin
        rd0_q    <= bmem[bram_addr[9:2]];
        rd3_q[0] <= bmem[u3_baddr[9:2]];
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end
    assign bram_rdata = rd0_q;
    assign u3_brdata  = rd3_q[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge g_clk);
        #1;
    endtask

    typedef struct {
        logic        en, req, wen, stall;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic        gnt, cen;
        logic [31:0] baddr;
        logic [3:0]  wstrb;
    } vec_t;

    vec_t        vecs [10];
    logic        gh [16];
    logic [8:0]  gpat;
    logic [31:0] exp3 [8];
    int          g3, r3;

    initial begin
        g_resetn = 1'b0; enable = 1'b1; mem_req = 1'b1; mem_addr = 32'h10;
        mem_wen = 1'b0; mem_strb = 4'h0; mem_wdata = 32'h0; mem_ack = 1'b0;
        bram_stall = 1'b0; u3_req = 1'b0; u3_addr = 32'h0;

        // Reset state, with a live request that must not be granted.
        step; #1;
        chk("rst_gnt", mem_gnt, 0);
        chk("rst_cen", bram_cen, 0);
        step; #1;
        chk("rst_recv", mem_recv, 0);
        chk("rst_err", mem_error, 0);
        chk("rst_rdata", mem_rdata, 0);
        g_resetn = 1'b1; mem_req = 1'b0; mem_ack = 1'b1;

        // Decode table: {en, req, wen, stall, strb, addr} -> {gnt, cen, bram_addr, bram_wstrb}
        vecs[0] = '{1, 1, 0, 0, 4'hF, 32'h0000_0010, 1, 1, 32'h0000_0010, 4'h0};
        vecs[1] = '{1, 1, 1, 0, 4'h3, 32'h0000_1234, 1, 1, 32'h0000_1234, 4'h3};
        vecs[2] = '{1, 1, 0, 1, 4'hF, 32'h0002_0000, 1, 0, 32'h0000_0000, 4'h0};
        vecs[3] = '{1, 1, 0, 1, 4'hF, 32'h0000_0010, 0, 1, 32'h0000_0010, 4'h0};
        vecs[4] = '{0, 1, 0, 0, 4'hF, 32'h0000_0010, 0, 0, 32'h0000_0000, 4'h0};
        vecs[5] = '{1, 0, 0, 0, 4'hF, 32'h0000_ABCD, 0, 0, 32'h0000_ABCD, 4'h0};
        vecs[6] = '{1, 1, 1, 0, 4'hC, 32'hFFFF_FFFC, 1, 0, 32'h0000_FFFC, 4'hC};
        vecs[7] = '{1, 1, 0, 0, 4'hF, 32'h0000_FFFC, 1, 1, 32'h0000_FFFC, 4'h0};
        vecs[8] = '{1, 1, 0, 0, 4'hF, 32'h0001_0000, 1, 0, 32'h0000_0000, 4'h0};
        vecs[9] = '{0, 0, 1, 0, 4'h5, 32'h0000_0040, 0, 0, 32'h0000_0000, 4'h5};
        for (int v = 0; v < 10; v++) begin
            step;
            enable = vecs[v].en; mem_req = vecs[v].req; mem_wen = vecs[v].wen;
            bram_stall = vecs[v].stall; mem_strb = vecs[v].strb; mem_addr = vecs[v].addr;
            #1;
            chk("tbl_gnt", mem_gnt, vecs[v].gnt);
            chk("tbl_cen", bram_cen, vecs[v].cen);
            chk("tbl_baddr", bram_addr, vecs[v].baddr);
            chk("tbl_wstrb", bram_wstrb, vecs[v].wstrb);
        end
        step;
        enable = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; bram_stall = 1'b0; mem_strb = 4'hF;
        repeat (4) step;
        chk("tbl_drained", mem_recv, 0);

        // In-window read, latency 1: response two cycles after grant.
        mem_ack = 1'b0;
        step; mem_req = 1'b1; mem_addr = 32'h10; #1;
        chk("rd_gnt", mem_gnt, 1);
        step; mem_req = 1'b0; #1;
        chk("rd_recv_early", mem_recv, 0);
        step; #1;
        chk("rd_recv", mem_recv, 1);
        chk("rd_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("rd_err", mem_error, 0);
        step; #1;
        chk("rd_hold", mem_rdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        step; mem_ack = 1'b0; #1;
        chk("rd_popped", mem_recv, 0);

        // Out-of-window read ignores stall and returns an error.
        step; mem_req = 1'b1; mem_addr = 32'h0002_0000; bram_stall = 1'b1; #1;
        chk("oow_gnt", mem_gnt, 1);
        chk("oow_cen", bram_cen, 0);
        step; mem_req = 1'b0; bram_stall = 1'b0; #1;
        chk("oow_recv_early", mem_recv, 0);
        step; #1;
        chk("oow_recv", mem_recv, 1);
        chk("oow_err", mem_error, 1);
        chk("oow_rdata", mem_rdata, 0);
        mem_ack = 1'b1;
        step; mem_ack = 1'b0; #1;
        chk("oow_popped", mem_recv, 0);

        // Credit exhaustion with ack low, then release with no pop bypass.
        for (int k = 0; k < 6; k++) begin
            step; mem_req = 1'b1; mem_addr = 32'h40 + 32'(4 * k); #1;
            chk("burst_gnt", mem_gnt, (k < 4) ? 1 : 0);
        end
        step; mem_addr = 32'h40; mem_ack = 1'b1; #1;
        chk("rel_gnt_nobypass", mem_gnt, 0);
        chk("rel_recv", mem_recv, 1);
        chk("rel_rdata0", mem_rdata, 32'hA000_0010);
        for (int k = 1; k < 4; k++) begin
            step; #1;
            chk("rel_gnt", mem_gnt, 1);
            chk("rel_rdata", mem_rdata, 32'hA000_0010 + 32'(k));
        end
        step; mem_req = 1'b0; #1;
        chk("rel_new_rsp", mem_rdata, 32'hA000_0010);
        step; step; step;
        chk("rel_drained", mem_recv, 0);
        mem_ack = 1'b0;

        // Write with strobes, then read back the merged word.
        step; mem_req = 1'b1; mem_wen = 1'b1; mem_strb = 4'h3; mem_wdata = 32'h1234_5678; mem_addr = 32'h80; #1;
        chk("wr_gnt", mem_gnt, 1);
        chk("wr_wstrb", bram_wstrb, 4'h3);
        chk("wr_wdata", bram_wdata, 32'h1234_5678);
        step; mem_wen = 1'b0; #1;
        chk("rb_gnt", mem_gnt, 1);
        chk("rb_wstrb", bram_wstrb, 4'h0);
        step; mem_req = 1'b0; #1;
        chk("wr_rsp_recv", mem_recv, 1);
        chk("wr_rsp_rdata", mem_rdata, 0);
        chk("wr_rsp_err", mem_error, 0);
        mem_ack = 1'b1;
        step; #1;
        chk("rb_rdata", mem_rdata, 32'hA000_5678);
        step; #1;
        chk("rb_popped", mem_recv, 0);
        mem_ack = 1'b0;

        // Reset with three requests outstanding drops all of them.
        for (int k = 0; k < 3; k++) begin
            step; mem_req = 1'b1; mem_addr = 32'h44; #1;
            chk("pre_rst_gnt", mem_gnt, 1);
        end
        step; mem_req = 1'b0; g_resetn = 1'b0; #1;
        chk("pre_rst_recv", mem_recv, 1);
        step; g_resetn = 1'b1; #1;
        chk("midrst_recv", mem_recv, 0);
        chk("midrst_rdata", mem_rdata, 0);
        repeat (3) step;
        chk("no_stale", mem_recv, 0);
        step; mem_req = 1'b1; mem_addr = 32'h10; #1;
        chk("fresh_gnt", mem_gnt, 1);
        step; mem_req = 1'b0;
        step; #1;
        chk("fresh_recv", mem_recv, 1);
        chk("fresh_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        step; step;
        mem_ack = 1'b0;

        // enable low blocks grants while two pending responses drain.
        for (int k = 0; k < 2; k++) begin
            step; mem_req = 1'b1; mem_addr = 32'h44 + 32'(4 * k); #1;
            chk("en_pre_gnt", mem_gnt, 1);
        end
        for (int k = 0; k < 5; k++) begin
            step; enable = 1'b0; mem_req = 1'b1; mem_addr = 32'h10; mem_ack = 1'b1; #1;
            chk("dis_gnt", mem_gnt, 0);
            chk("dis_cen", bram_cen, 0);
            chk("dis_recv", mem_recv, (k < 2) ? 1 : 0);
            if (k < 2) chk("dis_rdata", mem_rdata, 32'hA000_0011 + 32'(k));
        end
        step; enable = 1'b1; mem_req = 1'b0;

        // Latency 3, depth 4: a grant's credit returns only after its pop at t+4,
        // so the fifth request waits one cycle and the pattern repeats.
        gpat = 9'b1_1110_1111;
        exp3[0] = 32'hA000_0000; exp3[1] = 32'hA000_0001; exp3[2] = 32'hA000_0002;
        exp3[3] = 32'hA000_0003; exp3[4] = 32'hDEAD_BEEF; exp3[5] = 32'hA000_0005;
        exp3[6] = 32'hA000_0006; exp3[7] = 32'hA000_0007;
        g3 = 0; r3 = 0;
        for (int c = 0; c < 16; c++) begin
            step; u3_req = (g3 < 8); u3_addr = 32'(4 * g3); #1;
            if (c == 0) begin
                chk("l3_cen", u3_cen, 1);
                chk("l3_wstrb", u3_bwstrb, 0);
                chk("l3_wdata", u3_bwdata, mem_wdata);
            end
            chk("l3_gnt", u3_gnt, (c <= 8) ? 32'(gpat[c]) : 0);
            gh[c] = u3_gnt;
            if (c >= 4) chk("l3_recv", u3_recv, gh[c-4]);
            else        chk("l3_recv_early", u3_recv, 0);
            if (u3_recv && r3 < 8) begin
                chk("l3_rdata", u3_rdata, exp3[r3]);
                chk("l3_err", u3_error, 0);
                r3++;
            end
            if (u3_gnt) g3++;
        end
        u3_req = 1'b0;
        chk("l3_grants", g3, 8);
        chk("l3_rsps", r3, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
